// File: rtl/serial_operand_transmitter.sv
// Parallel-to-serial transmitter: accepts an operand pair over valid/ready and
// shifts both words out in lockstep with first/last markers for a serial comparator.
module serial_operand_transmitter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             out_en,
  output logic             a,
  output logic             b,
  output logic             out_valid,
  output logic             first,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [WIDTH-1:0] nx_a, nx_b;
  logic             a_q, a_d, b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic             first_q, first_d, last_q, last_d;
  logic             accept, xfer;

  assign a         = a_q;
  assign b         = b_q;
  assign out_valid = out_valid_q;
  assign first     = first_q;
  assign last      = last_q;

  // NOTE: every _d gets a default before any branch, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    last_d      = last_q;

    // Ready when idle or when the final bit leaves this cycle: no bubble between words.
    in_ready = rst & (~out_valid_q | (out_en & last_q));
    accept   = in_valid & in_ready;
    xfer     = out_valid_q & out_en;

    nx_a = MSB_FIRST ? (sh_a_q << 1) : (sh_a_q >> 1);
    nx_b = MSB_FIRST ? (sh_b_q << 1) : (sh_b_q >> 1);

    if (state_q == ST_SHIFT && xfer) begin
      if (last_q) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        a_d         = 1'b0;
        b_d         = 1'b0;
      end else begin
        sh_a_d  = nx_a;
        sh_b_d  = nx_b;
        cnt_d   = cnt_q + CW'(1);
        a_d     = MSB_FIRST ? nx_a[WIDTH-1] : nx_a[0];
        b_d     = MSB_FIRST ? nx_b[WIDTH-1] : nx_b[0];
        first_d = 1'b0;
        last_d  = (32'(cnt_q) + 32'd1 == WIDTH - 1);
      end
    end

    // Accept only happens while idle or on the last-bit transfer, so it overrides.
    if (accept) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      sh_a_d      = in_a;
      sh_b_d      = in_b;
      a_d         = MSB_FIRST ? in_a[WIDTH-1] : in_a[0];
      b_d         = MSB_FIRST ? in_b[WIDTH-1] : in_b[0];
      out_valid_d = 1'b1;
      first_d     = 1'b1;
      last_d      = (WIDTH == 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_transmitter.sv
// Directed bench: MSB-first and LSB-first 4-bit instances run side by side on
// shared stimulus, plus a 1-bit instance; expected bit streams are hand-derived.
module tb_serial_operand_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_en;
  logic [3:0] in_a, in_b;
  logic       rdy_m, a_m, b_m, v_m, f_m, l_m;
  logic       rdy_l, a_l, b_l, v_l, f_l, l_l;

  logic       in_valid1, out_en1;
  logic [0:0] in_a1, in_b1;
  logic       rdy_1, a_1, b_1, v_1, f_1, l_1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  serial_operand_transmitter #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_a(in_a), .in_b(in_b),
    .out_en(out_en), .a(a_m), .b(b_m), .out_valid(v_m), .first(f_m), .last(l_m));

  serial_operand_transmitter #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_a(in_a), .in_b(in_b),
    .out_en(out_en), .a(a_l), .b(b_l), .out_valid(v_l), .first(f_l), .last(l_l));

  serial_operand_transmitter #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(rdy_1), .in_a(in_a1), .in_b(in_b1),
    .out_en(out_en1), .a(a_1), .b(b_1), .out_valid(v_1), .first(f_1), .last(l_1));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs packed as {out_valid, first, last, a, b}.
  task automatic check_w4(input string tag, input logic [4:0] em, input logic [4:0] el);
    check({tag, "_msb"}, {3'b0, v_m, f_m, l_m, a_m, b_m}, {3'b0, em});
    check({tag, "_lsb"}, {3'b0, v_l, f_l, l_l, a_l, b_l}, {3'b0, el});
  endtask

  task automatic check_rdy(input string tag, input logic exp);
    check({tag, "_rdy_msb"}, {7'b0, rdy_m}, {7'b0, exp});
    check({tag, "_rdy_lsb"}, {7'b0, rdy_l}, {7'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // 4'b1010 / 4'b0110 serialised in each order.
  logic [4:0] exp_m [4] = '{5'b11010, 5'b10001, 5'b10011, 5'b10100};
  logic [4:0] exp_l [4] = '{5'b11000, 5'b10011, 5'b10001, 5'b10110};
  // 4'hF / 4'h0 is identical in both orders.
  logic [4:0] exp_f [4] = '{5'b11010, 5'b10010, 5'b10010, 5'b10110};

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_en = 1'b1; in_a = 4'h0; in_b = 4'h0;
    in_valid1 = 1'b0; out_en1 = 1'b1; in_a1 = 1'b0; in_b1 = 1'b0;
    step(); step();

    // Reset state
    check_w4("reset", 5'b00000, 5'b00000);
    check_rdy("reset", 1'b0);
    check("reset_w1", {3'b0, v_1, f_1, l_1, a_1, b_1}, 8'h00);
    check("reset_rdy_w1", {7'b0, rdy_1}, 8'h00);
    rst = 1'b1; #1;
    check_rdy("release", 1'b1);

    // Basic word in both bit orders
    in_valid = 1'b1; in_a = 4'b1010; in_b = 4'b0110;
    step();
    in_valid = 1'b0; in_a = 4'h5; in_b = 4'h9;  // late changes must not matter
    for (int i = 0; i < 4; i++) begin
      #1;
      check_w4($sformatf("basic_bit%0d", i), exp_m[i], exp_l[i]);
      check_rdy($sformatf("basic_bit%0d", i), (i == 3));
      step();
    end
    check_w4("basic_idle", 5'b00000, 5'b00000);
    check_rdy("basic_idle", 1'b1);

    // Stall of three cycles on bit 2
    in_valid = 1'b1; in_a = 4'b1010; in_b = 4'b0110;
    step();
    in_valid = 1'b0;
    check_w4("stall_bit0", exp_m[0], exp_l[0]);
    step();
    check_w4("stall_bit1", exp_m[1], exp_l[1]);
    step();
    out_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_w4($sformatf("stall_hold%0d", i), exp_m[2], exp_l[2]);
      check_rdy($sformatf("stall_hold%0d", i), 1'b0);
      step();
    end
    out_en = 1'b1;
    check_w4("stall_bit2", exp_m[2], exp_l[2]);
    step();
    out_en = 1'b0; #1;
    check_w4("stall_bit3_hold", exp_m[3], exp_l[3]);
    check_rdy("stall_last_hold", 1'b0);
    out_en = 1'b1; #1;
    check_rdy("stall_last_xfer", 1'b1);
    step();
    check_w4("stall_idle", 5'b00000, 5'b00000);

    // Back-to-back words with the second pair held valid throughout
    in_valid = 1'b1; in_a = 4'b1010; in_b = 4'b0110;
    step();
    in_a = 4'hF; in_b = 4'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_w4($sformatf("b2b_w1_bit%0d", i), exp_m[i], exp_l[i]);
      check_rdy($sformatf("b2b_w1_bit%0d", i), (i == 3));
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_w4($sformatf("b2b_w2_bit%0d", i), exp_f[i], exp_f[i]);
      step();
    end
    check_w4("b2b_idle", 5'b00000, 5'b00000);

    // Reset pulse on bit 1 discards the word
    in_valid = 1'b1; in_a = 4'b1010; in_b = 4'b0110;
    step();
    in_valid = 1'b0;
    step();
    check_w4("rstmid_bit1", exp_m[1], exp_l[1]);
    rst = 1'b0;
    step();
    check_w4("rstmid_cleared", 5'b00000, 5'b00000);
    check_rdy("rstmid_held", 1'b0);
    rst = 1'b1; #1;
    check_rdy("rstmid_release", 1'b1);
    step();
    check_w4("rstmid_idle", 5'b00000, 5'b00000);
    in_valid = 1'b1; in_a = 4'hF; in_b = 4'h0;
    step();
    in_valid = 1'b0;
    check_w4("rstmid_restart", exp_f[0], exp_f[0]);
    for (int i = 1; i < 4; i++) step();
    step();

    // WIDTH=1: single bit carries both markers; back-to-back accept on it
    in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0; #1;
    check("w1_rdy_idle", {7'b0, rdy_1}, 8'h01);
    step();
    in_a1 = 1'b0; in_b1 = 1'b1; #1;
    check("w1_word1", {3'b0, v_1, f_1, l_1, a_1, b_1}, {3'b0, 5'b11110});
    check("w1_rdy_last", {7'b0, rdy_1}, 8'h01);
    step();
    in_valid1 = 1'b0;
    check("w1_word2", {3'b0, v_1, f_1, l_1, a_1, b_1}, {3'b0, 5'b11101});
    out_en1 = 1'b0; #1;
    check("w1_rdy_stall", {7'b0, rdy_1}, 8'h00);
    step();
    check("w1_stall_hold", {3'b0, v_1, f_1, l_1, a_1, b_1}, {3'b0, 5'b11101});
    out_en1 = 1'b1;
    step();
    check("w1_idle", {3'b0, v_1, f_1, l_1}, 8'h00);
    check("w1_rdy_end", {7'b0, rdy_1}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_operand_transmitter.md
Name: serial_operand_transmitter

Overview:
- Parallel-to-serial transmitter that feeds the team's serial comparators.
- Accepts a pair of WIDTH-bit operands through a valid/ready handshake.
- Shifts both operands out in lockstep, one bit per transfer, MSB-first or LSB-first.
- Flags the first and last bit of each word so the downstream comparator can restart and sample its result.

Parameters:
- WIDTH, 8, operand width in bits; legal range is 1 or more.
- MSB_FIRST, 1, 1 = most significant bit first; 0 = least significant bit first.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous reset, active-low (rst == 0 resets).
- in_valid, input, 1, operand pair available.
- in_ready, output, 1, block can accept an operand pair this cycle.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- out_en, input, 1, downstream accepts the current bit; 0 stalls.
- a, output, 1, serial bit of A.
- b, output, 1, serial bit of B.
- out_valid, output, 1, a/b/first/last are meaningful.
- first, output, 1, current bit is the first bit of the word.
- last, output, 1, current bit is the final bit of the word.

Behaviour:
- Handshakes:
  - Input accept: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_en at a rising edge.
- Reset (rst == 0 at an edge):
  - Registered outputs a=0, b=0, out_valid=0, first=0, last=0.
  - FSM goes to ST_IDLE; bit counter = 0; shift registers = 0.
  - in_ready is forced to 0 while rst == 0.
- Reset mid-word: the word in flight is discarded with no further bits emitted. The first cycle after reset release is ST_IDLE with in_ready=1.
- FSM states: ST_IDLE, ST_SHIFT.
  - ST_IDLE: out_valid=0. On accept, load shift registers and go to ST_SHIFT with counter=0.
  - ST_SHIFT: out_valid=1.
    - On transfer with counter < WIDTH-1: advance shift registers, increment counter.
    - On transfer with counter == WIDTH-1: if an accept occurs in the same cycle, reload and stay in ST_SHIFT with counter=0. Otherwise go to ST_IDLE.
    - With out_en=0: hold all outputs and state unchanged.
- in_ready = rst & (~out_valid | (out_en & last)), combinational. This gives back-to-back words with no bubble.
- Latency: operand accepted at edge k, so bit 0 is on a/b with out_valid=1 during the cycle after edge k. A word takes exactly WIDTH transfers.
- Bit order:
  - MSB_FIRST=1: transfer i presents in_a[WIDTH-1-i] and in_b[WIDTH-1-i].
  - MSB_FIRST=0: transfer i presents in_a[i] and in_b[i].
- Markers:
  - first=1 only when counter == 0.
  - last=1 only when counter == WIDTH-1.
  - When WIDTH=1, both are 1 on the single bit.
  - Both are 0 whenever out_valid == 0.
- Counter width is $clog2(WIDTH) with a minimum of 1; it never exceeds WIDTH-1.
- in_a/in_b are sampled only at accept. Changes to them afterwards have no effect.
- in_valid while in_ready == 0 is ignored; the source must hold it.
- All outputs except in_ready are registered.

Test Plan:
- Basic MSB-first: WIDTH=4, MSB_FIRST=1, in_a=4'b1010, in_b=4'b0110, out_en=1.
  - a = 1,0,1,0 and b = 0,1,1,0 on 4 consecutive cycles.
  - first on bit 0, last on bit 3; then out_valid=0 and in_ready=1.
- LSB-first: MSB_FIRST=0, same operands.
  - a = 0,1,0,1 and b = 0,1,1,0.
  - first/last on the same cycles as the MSB-first case.
- Stall: out_en=0 for 3 cycles at bit 2 of a word.
  - a/b/first/last/out_valid hold for those 3 cycles.
  - Word completes in 4 transfers (7 cycles); in_ready stays 0 until the last-bit transfer.
- Back-to-back: second pair (in_a=4'hF, in_b=4'h0) held valid during the first word.
  - Accepted on the cycle with last & out_en.
  - Its bit 0 (first=1, a=1, b=0) follows in the very next cycle; out_valid never drops.
- Reset mid-word: rst=0 for 1 cycle at bit 1.
  - Next cycle: out_valid=0, first=0, last=0, a=0, b=0.
  - After release, in_ready=1; a new word starts cleanly with first=1.
- WIDTH=1: in_a=1, in_b=0 accepted.
  - One cycle with a=1, b=0, first=1, last=1.
  - A new word is accepted in that same cycle if in_valid=1.
